// File: rtl/inst_fetch.sv
// Instruction-fetch stage: issues one imem read per PC, buffers the returned word
// in a valid/ready register for decode, and drives the PC register's next-PC/stall.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic [32:0] pc_from_fetch,
    output logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adel,
    input  logic        id_ready
);

    typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] skid_inst;
    logic        free;
    logic        pc_misaligned;
    logic        advance;
    logic        skid_load;
    logic [31:0] load_inst;
    logic        load_adel;

    assign free          = !if_valid || id_ready;
    assign pc_misaligned = pc[1:0] != 2'b00;
    assign imem_addr     = pc;
    assign stall         = !advance;
    assign pc_from_fetch = {advance, pc + 32'd4};

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        advance   = 1'b0;
        load_inst = NOP_INST;
        load_adel = 1'b0;
        skid_load = 1'b0;
        case (state)
            REQ: begin
                imem_req = !flush && !pc_misaligned;
                if (!flush) begin
                    // A misaligned PC never reaches memory; it retires as a flagged NOP.
                    if (pc_misaligned) begin
                        if (free) begin
                            advance   = 1'b1;
                            load_adel = 1'b1;
                        end
                    end else if (imem_gnt) begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (flush) begin
                        state_nxt = REQ;
                    end else if (free) begin
                        advance   = 1'b1;
                        load_inst = imem_rdata;
                        state_nxt = REQ;
                    end else begin
                        skid_load = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if (flush) begin
                    state_nxt = DROP;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_nxt = REQ;
                end else if (free) begin
                    advance   = 1'b1;
                    load_inst = skid_inst;
                    state_nxt = REQ;
                end
            end
            DROP: begin
                if (imem_rvalid && !flush) begin
                    state_nxt = REQ;
                end else if (imem_rvalid) begin
                    state_nxt = REQ;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= REQ;
            skid_inst <= NOP_INST;
        end else begin
            state <= state_nxt;
            if (skid_load) begin
                skid_inst <= imem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_pc    <= RESET_PC;
            if_inst  <= NOP_INST;
            if_adel  <= 1'b0;
        end else if (flush) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
            if_adel  <= 1'b0;
        end else if (advance) begin
            if_valid <= 1'b1;
            if_pc    <= pc;
            if_inst  <= load_inst;
            if_adel  <= load_adel;
        end else if (id_ready) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
            if_adel  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed corner sequences, a vector table, and a randomized
// run against a flag-level model of fetch, PC register and instruction memory.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] pc;
    logic        flush;
    logic [32:0] pc_from_fetch;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;
    logic        id_ready;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .flush(flush),
        .pc_from_fetch(pc_from_fetch), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_adel(if_adel),
        .id_ready(id_ready)
    );

    int checks = 0;
    int errors = 0;

    // Model: outstanding read, stale (flushed) read, parked word, decode register.
    logic        m_out, m_stale, m_held, m_valid, m_adel;
    logic [31:0] m_held_word, m_pc, m_inst;
    logic        e_req, e_adv, e_ld_adel;
    logic [31:0] e_ld_inst, redirect, pc_next;

    logic        mem_pend;
    logic [31:0] mem_addr;
    int          mem_dly;
    int          delivered;

    typedef struct {
        logic [31:0] pc;
        logic        flush;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_new;
        logic        exp_adv;
    } vec_t;
    vec_t vecs[8];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_out = 0; m_stale = 0; m_held = 0; m_held_word = '0;
        m_valid = 0; m_adel = 0; m_pc = RESET_PC; m_inst = NOP_INST;
        mem_pend = 0; mem_dly = 0; mem_addr = '0;
    endtask

    task automatic predict();
        logic aligned;
        logic resp;
        logic fr;
        aligned = (pc[1:0] == 2'b00);
        resp    = imem_rvalid && m_out;
        fr      = !m_valid || id_ready;
        e_req     = !flush && aligned && !m_out && !m_held;
        e_adv     = 0;
        e_ld_inst = NOP_INST;
        e_ld_adel = 0;
        if (!flush) begin
            if (m_held) begin
                if (fr) begin e_adv = 1; e_ld_inst = m_held_word; end
            end else if (resp && !m_stale) begin
                if (fr) begin e_adv = 1; e_ld_inst = imem_rdata; end
            end else if (!m_out && !aligned && fr) begin
                e_adv = 1; e_ld_adel = 1;
            end
        end
    endtask

    task automatic check_model();
        chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
        chk("imem_addr", imem_addr, pc);
        chk("pc_new", pc_from_fetch[31:0], pc + 32'd4);
        chk("pc_en", {31'd0, pc_from_fetch[32]}, {31'd0, e_adv});
        chk("stall", {31'd0, stall}, {31'd0, !e_adv});
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        chk("if_inst", if_inst, m_valid ? m_inst : NOP_INST);
        if (m_valid) begin
            chk("if_pc", if_pc, m_pc);
            chk("if_adel", {31'd0, if_adel}, {31'd0, m_adel});
        end
    endtask

    task automatic update();
        logic resp;
        logic fr;
        resp = imem_rvalid && m_out;
        fr   = !m_valid || id_ready;
        if (flush) m_valid = 0;
        else if (e_adv) begin m_valid = 1; m_pc = pc; m_inst = e_ld_inst; m_adel = e_ld_adel; end
        else if (id_ready) m_valid = 0;
        if (flush) m_held = 0;
        else if (resp && !m_stale && !fr) begin m_held = 1; m_held_word = imem_rdata; end
        else if (m_held && fr) m_held = 0;
        if (e_req && imem_gnt) begin m_out = 1; m_stale = 0; end
        else if (resp) begin m_out = 0; m_stale = 0; end
        else if (flush && m_out) m_stale = 1;
        if (flush) pc_next = redirect;
        else if (e_adv) pc_next = pc + 32'd4;
        else pc_next = pc;
    endtask

    task automatic drive(input logic f, input logic g, input logic rv, input logic [31:0] rd,
                         input logic rdy, input logic [31:0] tgt);
        flush = f; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; id_ready = rdy; redirect = tgt;
        #3;
        predict();
        check_model();
    endtask

    task automatic step();
        update();
        @(posedge clk);
        #1;
        pc = pc_next;
    endtask

    task automatic do_reset();
        rst_n = 0;
        flush = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; id_ready = 0; redirect = '0;
        pc = RESET_PC;
        reset_model();
        #2;
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, RESET_PC);
        chk("rst_if_inst", if_inst, NOP_INST);
        chk("rst_if_adel", {31'd0, if_adel}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd1);
        chk("rst_req", {31'd0, imem_req}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        logic        f, g, rv, rdy;
        logic [31:0] rd, tgt;
        pc = RESET_PC; flush = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        id_ready = 0; redirect = '0; delivered = 0;
        reset_model();

        vecs[0] = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b0};
        vecs[1] = '{32'h0000_1000, 1'b0, 1'b0, 1'b1, 32'h0000_1004, 1'b0};
        vecs[2] = '{32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0};
        vecs[3] = '{32'h0000_0006, 1'b0, 1'b1, 1'b0, 32'h0000_000A, 1'b1};
        vecs[4] = '{32'h0000_0007, 1'b0, 1'b0, 1'b0, 32'h0000_000B, 1'b1};
        vecs[5] = '{32'h0000_0005, 1'b1, 1'b1, 1'b0, 32'h0000_0009, 1'b0};
        vecs[6] = '{32'h0000_0080, 1'b1, 1'b0, 1'b0, 32'h0000_0084, 1'b0};
        vecs[7] = '{32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 1'b1};

        #1;
        do_reset();

        // Single fetch: gnt at t, rvalid at t+1
        drive(0, 1, 0, '0, 1, '0);
        chk("t1_stall_t", {31'd0, stall}, 32'd1);
        step();
        drive(0, 0, 1, 32'h2408_0001, 1, '0);
        chk("t1_adv", {31'd0, pc_from_fetch[32]}, 32'd1);
        chk("t1_pcnew", pc_from_fetch[31:0], 32'h0000_0004);
        step();
        // Backpressure into the skid
        drive(0, 1, 0, '0, 0, '0);
        chk("t1_valid", {31'd0, if_valid}, 32'd1);
        chk("t1_pc", if_pc, 32'h0000_0000);
        chk("t1_inst", if_inst, 32'h2408_0001);
        chk("t1_stall", {31'd0, stall}, 32'd1);
        step();
        drive(0, 0, 1, 32'h8C09_0004, 0, '0);
        chk("t2_stall_rv", {31'd0, stall}, 32'd1);
        step();
        drive(0, 0, 0, '0, 0, '0);
        chk("t2_hold_req", {31'd0, imem_req}, 32'd0);
        chk("t2_hold_stall", {31'd0, stall}, 32'd1);
        step();
        drive(0, 0, 0, '0, 1, '0);
        chk("t2_adv", {31'd0, pc_from_fetch[32]}, 32'd1);
        step();
        drive(0, 1, 0, '0, 1, '0);
        chk("t2_inst", if_inst, 32'h8C09_0004);
        chk("t2_pc", if_pc, 32'h0000_0004);
        chk("t2_pc_once", imem_addr, 32'h0000_0008);
        step();
        // Flush while waiting, late rvalid dropped
        drive(1, 0, 0, '0, 1, 32'h0000_0100);
        chk("t3_req", {31'd0, imem_req}, 32'd0);
        step();
        drive(0, 1, 1, 32'hDEAD_BEEF, 1, '0);
        chk("t3_drop_req", {31'd0, imem_req}, 32'd0);
        chk("t3_drop_adv", {31'd0, pc_from_fetch[32]}, 32'd0);
        step();
        drive(0, 1, 0, '0, 1, '0);
        chk("t3_new_req", {31'd0, imem_req}, 32'd1);
        chk("t3_new_addr", imem_addr, 32'h0000_0100);
        chk("t3_no_valid", {31'd0, if_valid}, 32'd0);
        step();
        drive(0, 0, 1, mem_word(32'h0000_0100), 1, '0);
        step();
        drive(0, 1, 0, '0, 1, '0);
        chk("t3_inst", if_inst, mem_word(32'h0000_0100));
        chk("t3_pc", if_pc, 32'h0000_0100);
        step();
        // Flush coincident with rvalid
        drive(1, 0, 1, 32'hCAFE_F00D, 1, 32'h0000_0200);
        chk("t4_adv", {31'd0, pc_from_fetch[32]}, 32'd0);
        step();
        drive(0, 0, 0, '0, 1, '0);
        chk("t4_valid", {31'd0, if_valid}, 32'd0);
        chk("t4_req", {31'd0, imem_req}, 32'd1);
        chk("t4_addr", imem_addr, 32'h0000_0200);
        step();
        // Misaligned PC
        drive(1, 0, 0, '0, 1, 32'h0000_0006);
        step();
        drive(0, 0, 0, '0, 1, '0);
        chk("t5_req", {31'd0, imem_req}, 32'd0);
        chk("t5_pcnew", pc_from_fetch[31:0], 32'h0000_000A);
        chk("t5_adv", {31'd0, pc_from_fetch[32]}, 32'd1);
        step();
        drive(1, 0, 0, '0, 1, 32'h0000_0300);
        chk("t5_valid", {31'd0, if_valid}, 32'd1);
        chk("t5_adel", {31'd0, if_adel}, 32'd1);
        chk("t5_inst", if_inst, NOP_INST);
        chk("t5_pc", if_pc, 32'h0000_0006);
        step();
        // Reset with a grant outstanding, late rvalid ignored, then PC wrap
        drive(0, 1, 0, '0, 1, '0);
        step();
        do_reset();
        drive(0, 0, 1, 32'h1111_2222, 1, '0);
        chk("t6_late_adv", {31'd0, pc_from_fetch[32]}, 32'd0);
        step();
        drive(0, 0, 0, '0, 1, '0);
        chk("t6_valid", {31'd0, if_valid}, 32'd0);
        step();
        drive(1, 0, 0, '0, 1, 32'hFFFF_FFFC);
        step();
        drive(0, 0, 0, '0, 1, '0);
        chk("t6_wrap", pc_from_fetch[31:0], 32'h0000_0000);
        step();

        for (int i = 0; i < 8; i++) begin
            do_reset();
            pc = vecs[i].pc;
            drive(vecs[i].flush, 0, 0, '0, vecs[i].rdy, '0);
            chk("vec_req", {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
            chk("vec_pcnew", pc_from_fetch[31:0], vecs[i].exp_new);
            chk("vec_adv", {31'd0, pc_from_fetch[32]}, {31'd0, vecs[i].exp_adv});
            step();
        end

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            f   = ($urandom_range(0, 11) == 0);
            tgt = $urandom & ~32'h3;
            if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            g   = 1'($urandom_range(0, 1));
            rv  = 0;
            rd  = $urandom;
            if (mem_pend && mem_dly == 0) begin
                rv = 1;
                rd = mem_word(mem_addr);
            end else if (!mem_pend && $urandom_range(0, 19) == 0) begin
                rv = 1;
            end
            rdy = ($urandom_range(0, 9) < 7);
            drive(f, g, rv, rd, rdy, tgt);
            if (m_valid && !m_adel) chk("rand_word", if_inst, mem_word(m_pc));
            if (if_valid && id_ready && !if_adel) delivered++;
            if (mem_pend && mem_dly == 0) mem_pend = 0;
            else if (mem_pend) mem_dly--;
            if (imem_req && g) begin
                mem_pend = 1;
                mem_addr = imem_addr;
                mem_dly  = int'($urandom_range(0, 2));
            end
            step();
        end
        chk("liveness", {31'd0, delivered >= 100}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
